clock_25: RTL and testbench

Clock divider that derives the 25 MHz pixel/video clock `clk25` from the 50 MHz board clock `clk`. It also provides a single-cycle `tick` strobe for logic that stays in the `clk` domain. It sits at the top of the clocking tree and feeds the VGA timing and game-rendering logic. The division ratio is a parameter; the default divides by 2.

---
 rtl/clock_25.sv | 52 +++++
 tb/tb_clock_25.sv | 140 ++++++++++++++
 2 files changed

// File: rtl/clock_25.sv
// rtl/clock_25.sv - clk/DIV divider producing registered clk25 and a clk-domain tick strobe
module clock_25 #(
    parameter int DIV = 2,
    parameter int CW  = ($clog2(DIV) > 1) ? $clog2(DIV) : 1
) (
    input  logic clk,
    input  logic rst_n,
    output logic clk25,
    output logic tick
);

    localparam logic [CW-1:0] RISE_AT = CW'(DIV / 2 - 1);
    localparam logic [CW-1:0] FALL_AT = CW'(DIV - 1);

    logic [CW-1:0] cnt;

    generate
        if ((DIV < 2) || ((DIV % 2) != 0)) begin : g_div_check
            $error("clock_25: DIV must be an even integer >= 2");
        end
    endgenerate

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (cnt == FALL_AT) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + CW'(1);
        end
    end

    // Explicit set/clear instead of a toggle keeps the phase tied to cnt even after a truncated period.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            clk25 <= 1'b0;
        end else if (cnt == RISE_AT) begin
            clk25 <= 1'b1;
        end else if (cnt == FALL_AT) begin
            clk25 <= 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tick <= 1'b0;
        end else begin
            tick <= (cnt == RISE_AT);
        end
    end

endmodule

// File: tb/tb_clock_25.sv
// tb/tb_clock_25.sv - scoreboard bench for clock_25 at DIV 2, 4 and 6
module tb_clock_25;

    typedef struct packed {
        logic       c2;
        logic       t2;
        logic       c4;
        logic       t4;
        logic       c6;
        logic       t6;
        logic [2:0] k6;
    } exp_t;

    logic clk;
    logic rst_n;
    logic c2, t2, c4, t4, c6, t6;

    int   checks;
    int   errors;
    int   n_edge;
    exp_t sb_q[$];

    logic win;
    int   rises2;
    int   rises4;

    clock_25 #(.DIV(2)) u2 (.clk(clk), .rst_n(rst_n), .clk25(c2), .tick(t2));
    clock_25 #(.DIV(4)) u4 (.clk(clk), .rst_n(rst_n), .clk25(c4), .tick(t4));
    clock_25 #(.DIV(6)) u6 (.clk(clk), .rst_n(rst_n), .clk25(c6), .tick(t6));

    initial clk = 1'b0;
    always #10 clk = ~clk;

    task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s at %0t: got %0h expected %0h", tag, $time, got, exp);
        end
    endtask

    function automatic logic exp_hi(input int n, input int d);
        return (n > 0) && ((n % d) >= (d / 2));
    endfunction

    function automatic logic exp_tick(input int n, input int d);
        return (n > 0) && ((n % d) == (d / 2));
    endfunction

    // Expected outputs after each edge depend only on edges seen since release.
    always @(posedge clk) begin
        exp_t e;
        if (rst_n) n_edge = n_edge + 1;
        else       n_edge = 0;
        e.c2 = exp_hi(n_edge, 2);
        e.t2 = exp_tick(n_edge, 2);
        e.c4 = exp_hi(n_edge, 4);
        e.t4 = exp_tick(n_edge, 4);
        e.c6 = exp_hi(n_edge, 6);
        e.t6 = exp_tick(n_edge, 6);
        e.k6 = 3'(n_edge % 6);
        sb_q.push_back(e);
    end

    always @(negedge clk) begin
        exp_t e;
        if (sb_q.size() > 0) begin
            e = sb_q.pop_front();
            check("clk25_div2", {7'd0, c2}, {7'd0, e.c2});
            check("tick_div2",  {7'd0, t2}, {7'd0, e.t2});
            check("clk25_div4", {7'd0, c4}, {7'd0, e.c4});
            check("tick_div4",  {7'd0, t4}, {7'd0, e.t4});
            check("clk25_div6", {7'd0, c6}, {7'd0, e.c6});
            check("tick_div6",  {7'd0, t6}, {7'd0, e.t6});
            check("cnt_div6",   {5'd0, u6.cnt}, {5'd0, e.k6});
        end
    end

    always @(posedge c2) if (win) rises2++;
    always @(posedge c4) if (win) rises4++;

    initial begin
        int ticks2;
        int high2;
        int ticks4;
        checks = 0;
        errors = 0;
        n_edge = 0;
        win    = 1'b0;
        rises2 = 0;
        rises4 = 0;
        ticks2 = 0;
        high2  = 0;
        ticks4 = 0;

        rst_n = 1'b0;
        #1;
        check("reset_clk25", {5'd0, c2, c4, c6}, 8'd0);
        check("reset_tick",  {5'd0, t2, t4, t6}, 8'd0);

        // Hold reset ~100 ns, release between edges.
        repeat (5) @(posedge clk);
        #5 rst_n = 1'b1;

        repeat (13) @(posedge clk);
        #5;
        check("pre_drop_clk25_div2", {7'd0, c2}, 8'd1);
        @(negedge clk);
        #5 rst_n = 1'b0;
        #1;
        check("async_clk25", {5'd0, c2, c4, c6}, 8'd0);
        check("async_tick",  {5'd0, t2, t4, t6}, 8'd0);
        check("async_cnt",   {5'd0, u6.cnt}, 8'd0);

        repeat (3) @(posedge clk);
        #5 rst_n = 1'b1;

        repeat (7) @(posedge clk);
        @(negedge clk);
        win = 1'b1;
        for (int i = 0; i < 1000; i++) begin
            @(negedge clk);
            if (t2) ticks2++;
            if (c2) high2++;
            if (t4) ticks4++;
        end
        win = 1'b0;
        check("long_rises_div2", 8'(rises2 / 4), 8'(500 / 4));
        check("long_rises_div2_lo", 8'(rises2 % 4), 8'(500 % 4));
        check("long_ticks_div2", 8'(ticks2 / 4), 8'(500 / 4));
        check("long_high_div2",  8'(high2 / 4), 8'(500 / 4));
        check("long_rises_div4", 8'(rises4), 8'd250);
        check("long_ticks_div4", 8'(ticks4), 8'd250);

        @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
